// File: rtl/cga_vram_arbiter_pkg.sv
// Shared widths, FSM states and the latched ISA request type for the video RAM arbiter.
package cga_vram_arbiter_pkg;

  localparam int unsigned SLOTS_DEF = 32;
  localparam int unsigned SEQ_W     = 5;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned DATA_W    = 8;

  localparam logic [SLOTS_DEF-1:0] PIX_SLOT_MASK_DEF = 32'h0000_3333;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } isa_req_t;

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// Bundle of sequencer, pixel-fetch, ISA and SRAM pin signals around the arbiter.
interface cga_vram_arbiter_if;
  import cga_vram_arbiter_pkg::*;

  logic [SEQ_W-1:0]  clk_seq;
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              isa_rd;
  logic              isa_wr;
  logic [ADDR_W-1:0] isa_addr;
  logic [DATA_W-1:0] isa_din;
  logic [DATA_W-1:0] isa_dout;
  logic              bus_rdy;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_doe;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we_l;

  modport master (
    output clk_seq, pix_req, pix_addr, isa_rd, isa_wr, isa_addr, isa_din, ram_din,
    input  pix_data, pix_valid, isa_dout, bus_rdy, ram_a, ram_dout, ram_doe, ram_we_l
  );

  modport slave (
    input  clk_seq, pix_req, pix_addr, isa_rd, isa_wr, isa_addr, isa_din, ram_din,
    output pix_data, pix_valid, isa_dout, bus_rdy, ram_a, ram_dout, ram_doe, ram_we_l
  );

endinterface

// File: rtl/cga_vram_arbiter_slot_window.sv
// Decodes the current phase into "pixel slot now" and "next phase opens a free
// two-cycle ISA window", with the window allowed to span the SLOTS-1 -> 0 wrap.
module cga_vram_arbiter_slot_window
  import cga_vram_arbiter_pkg::*;
#(
  parameter int unsigned      SLOTS = SLOTS_DEF,
  parameter logic [SLOTS-1:0] MASK  = PIX_SLOT_MASK_DEF
) (
  input  logic [SEQ_W-1:0] clk_seq,
  output logic             pix_slot_c,
  output logic             next_free_c
);

  logic [SEQ_W-1:0] ph1;
  logic [SEQ_W-1:0] ph2;

  function automatic logic [SEQ_W-1:0] succ(input logic [SEQ_W-1:0] ph);
    return (ph == SEQ_W'(SLOTS - 1)) ? '0 : ph + SEQ_W'(1);
  endfunction

  always_comb begin
    ph1         = succ(clk_seq);
    ph2         = succ(ph1);
    pix_slot_c  = MASK[clk_seq];
    next_free_c = ~MASK[ph1] & ~MASK[ph2];
  end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Time-slot arbiter for the shared video SRAM: pixel fetch owns masked phases,
// one latched ISA access runs per strobe in the next free SETUP/STROBE window.
module cga_vram_arbiter
  import cga_vram_arbiter_pkg::*;
#(
  parameter int unsigned      SLOTS         = SLOTS_DEF,
  parameter logic [SLOTS-1:0] PIX_SLOT_MASK = PIX_SLOT_MASK_DEF,
  parameter bit               USE_BUS_WAIT  = 1'b1
) (
  input logic               clk,
  input logic               reset_l,
  cga_vram_arbiter_if.slave bus
);

  state_t            state_q, state_d;
  isa_req_t          req_q, req_d;
  logic              strobe, strobe_q;
  logic              pix_slot_c, next_free_c, pix_hit;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic              ram_doe_q, ram_doe_d;
  logic              ram_we_l_q, ram_we_l_d;
  logic              bus_rdy_q, bus_rdy_d;
  logic [DATA_W-1:0] isa_dout_q, isa_dout_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;

  cga_vram_arbiter_slot_window #(
    .SLOTS (SLOTS),
    .MASK  (PIX_SLOT_MASK)
  ) u_window (
    .clk_seq     (bus.clk_seq),
    .pix_slot_c  (pix_slot_c),
    .next_free_c (next_free_c)
  );

  assign strobe  = bus.isa_rd | bus.isa_wr;
  assign pix_hit = pix_slot_c & bus.pix_req;

  // Next state and next registered outputs; pixel fetch is independent of the FSM.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ram_a_d     = ram_a_q;
    ram_doe_d   = ram_doe_q;
    ram_we_l_d  = 1'b1;
    bus_rdy_d   = bus_rdy_q;
    isa_dout_d  = isa_dout_q;
    pix_valid_d = pix_hit;
    pix_data_d  = pix_hit ? bus.ram_din : pix_data_q;

    case (state_q)
      ST_IDLE: begin
        if (strobe && !strobe_q) begin
          req_d.wr   = bus.isa_wr;
          req_d.addr = bus.isa_addr;
          req_d.data = bus.isa_din;
          state_d    = ST_PEND;
          if (USE_BUS_WAIT) bus_rdy_d = 1'b0;
        end
      end
      ST_PEND: begin
        if (next_free_c) begin
          state_d   = ST_SETUP;
          ram_a_d   = req_q.addr;
          ram_doe_d = req_q.wr;
        end
      end
      ST_SETUP: begin
        state_d    = ST_STROBE;
        ram_we_l_d = ~req_q.wr;
        if (!req_q.wr) isa_dout_d = bus.ram_din;
      end
      ST_STROBE: begin
        // A strobe already released means the access was posted; skip DONE.
        ram_doe_d = 1'b0;
        bus_rdy_d = 1'b1;
        state_d   = strobe ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (!strobe) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      strobe_q    <= 1'b0;
      ram_a_q     <= '0;
      ram_doe_q   <= 1'b0;
      ram_we_l_q  <= 1'b1;
      bus_rdy_q   <= 1'b1;
      isa_dout_q  <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      strobe_q    <= strobe;
      ram_a_q     <= ram_a_d;
      ram_doe_q   <= ram_doe_d;
      ram_we_l_q  <= ram_we_l_d;
      bus_rdy_q   <= bus_rdy_d;
      isa_dout_q  <= isa_dout_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  // Pixel address must reach the pins in the same cycle as its slot.
  assign bus.ram_a     = pix_hit ? bus.pix_addr : ram_a_q;
  assign bus.ram_dout  = req_q.data;
  assign bus.ram_doe   = ram_doe_q;
  assign bus.ram_we_l  = ram_we_l_q;
  assign bus.bus_rdy   = bus_rdy_q;
  assign bus.isa_dout  = isa_dout_q;
  assign bus.pix_data  = pix_data_q;
  assign bus.pix_valid = pix_valid_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed plus randomized bench for cga_vram_arbiter with an SRAM model and
// a phase-arithmetic reference for ISA window timing and memory contents.
module tb_cga_vram_arbiter;
  import cga_vram_arbiter_pkg::*;

  localparam logic [31:0] MASK_A = 32'h0000_3333;
  localparam logic [31:0] MASK_B = 32'h7FFF_FFFE;
  localparam int unsigned MEM_N  = 1 << ADDR_W;

  logic       clk     = 1'b0;
  logic       reset_l = 1'b0;
  logic [4:0] seq     = '0;

  always #5 clk = ~clk;
  always @(posedge clk) seq <= seq + 5'd1;

  cga_vram_arbiter_if if_a ();
  cga_vram_arbiter_if if_b ();

  assign if_a.clk_seq = seq;
  assign if_b.clk_seq = seq;

  cga_vram_arbiter #(.SLOTS(32), .PIX_SLOT_MASK(MASK_A), .USE_BUS_WAIT(1'b1))
    dut_a (.clk(clk), .reset_l(reset_l), .bus(if_a));
  cga_vram_arbiter #(.SLOTS(32), .PIX_SLOT_MASK(MASK_B), .USE_BUS_WAIT(1'b1))
    dut_b (.clk(clk), .reset_l(reset_l), .bus(if_b));

  // SRAM models (environment) and reference contents (expectation).
  logic [7:0] mem_a [MEM_N];
  logic [7:0] mem_b [MEM_N];
  logic [7:0] ref_a [MEM_N];
  logic [7:0] ref_b [MEM_N];

  assign if_a.ram_din = mem_a[if_a.ram_a];
  assign if_b.ram_din = mem_b[if_b.ram_a];

  always @(posedge clk) begin
    if (if_a.ram_we_l == 1'b0) mem_a[if_a.ram_a] <= if_a.ram_dout;
    if (if_b.ram_we_l == 1'b0) mem_b[if_b.ram_a] <= if_b.ram_dout;
  end

  int n_chk  = 0;
  int n_pass = 0;

  bit          pix_on, fix_req;
  logic [18:0] fix_addr;
  bit          rec_hit, exp_hit, cur_hit;
  logic [7:0]  rec_data, exp_data;
  logic [18:0] cur_addr;
  logic [18:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit free_ph(input logic [31:0] m, input int n);
    return !m[n % 32] && !m[(n + 1) % 32];
  endfunction

  // Request seen in phase p: PEND from p+1, SETUP lands on the first free phase at or after p+2.
  function automatic int setup_off(input logic [31:0] m, input int p);
    for (int off = 2; off < 36; off++)
      if (free_ph(m, (p + off) % 32)) return off;
    return 2;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    exp_hit  = rec_hit;
    exp_data = rec_data;
    if (fix_req) begin
      if_a.pix_req  = 1'b1;
      if_a.pix_addr = fix_addr;
      fix_req       = 1'b0;
    end else if (pix_on) begin
      if_a.pix_req  = 1'($urandom_range(0, 1));
      if_a.pix_addr = 19'($urandom);
    end else begin
      if_a.pix_req = 1'b0;
    end
    cur_hit  = MASK_A[seq] && if_a.pix_req;
    cur_addr = if_a.pix_addr;
    rec_hit  = cur_hit;
    rec_data = ref_a[cur_addr];
  endtask

  task automatic sample();
    @(negedge clk);
    chk("pix_valid", 32'(if_a.pix_valid), 32'(exp_hit));
    if (exp_hit) chk("pix_data", 32'(if_a.pix_data), 32'(exp_data));
    if (cur_hit) chk("pix_ram_a", 32'(if_a.ram_a), 32'(cur_addr));
  endtask

  task automatic idle_until(input int ph);
    for (int i = 0; i < 40; i++) begin
      if (seq == 5'(ph - 1)) break;
      cycle();
      sample();
    end
  endtask

  task automatic drive(input bit b, input bit rd, input bit wr, input logic [18:0] a, input logic [7:0] d);
    if (b) begin
      if_b.isa_rd = rd; if_b.isa_wr = wr; if_b.isa_addr = a; if_b.isa_din = d;
    end else begin
      if_a.isa_rd = rd; if_a.isa_wr = wr; if_a.isa_addr = a; if_a.isa_din = d;
    end
  endtask

  task automatic xact(input bit b, input bit rd, input bit wr, input logic [18:0] a,
                      input logic [7:0] d, input bit posted, input int hold);
    logic [31:0] m;
    int p, s;
    logic g_rdy, g_we, g_doe;
    logic [18:0] g_a;
    logic [7:0]  g_dout, g_rd, e_rd;
    m = b ? MASK_B : MASK_A;
    cycle();
    drive(b, rd, wr, a, d);
    p = int'(seq);
    s = setup_off(m, p);
    for (int k = 0; k <= s + 2; k++) begin
      if (k > 0) begin
        cycle();
        if (posted && k == 1) drive(b, 1'b0, 1'b0, a, d);
      end
      sample();
      g_rdy  = b ? if_b.bus_rdy  : if_a.bus_rdy;
      g_we   = b ? if_b.ram_we_l : if_a.ram_we_l;
      g_doe  = b ? if_b.ram_doe  : if_a.ram_doe;
      g_a    = b ? if_b.ram_a    : if_a.ram_a;
      g_dout = b ? if_b.ram_dout : if_a.ram_dout;
      g_rd   = b ? if_b.isa_dout : if_a.isa_dout;
      chk("bus_rdy", 32'(g_rdy), 32'((k == 0) || (k > s + 1)));
      chk("ram_we_l", 32'(g_we), 32'(!(wr && k == s + 1)));
      chk("ram_doe", 32'(g_doe), 32'(wr && (k == s || k == s + 1)));
      if (k == s || k == s + 1) begin
        chk("isa_ram_a", 32'(g_a), 32'(a));
        if (wr) chk("ram_dout", 32'(g_dout), 32'(d));
      end
      if (wr && k == s + 1) begin
        if (b) ref_b[a] = d; else ref_a[a] = d;
      end
      if (!wr && k == s + 2) begin
        e_rd = b ? ref_b[a] : ref_a[a];
        chk("isa_dout", 32'(g_rd), 32'(e_rd));
      end
    end
    for (int k = 0; k < hold; k++) begin
      cycle();
      sample();
      chk("hold_rdy", 32'(b ? if_b.bus_rdy : if_a.bus_rdy), 32'(1));
      chk("hold_we_l", 32'(b ? if_b.ram_we_l : if_a.ram_we_l), 32'(1));
    end
    cycle();
    drive(b, 1'b0, 1'b0, a, d);
    sample();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] ra;
    logic [7:0]  old;
    bit          seen;

    for (int i = 0; i < int'(MEM_N); i++) begin
      mem_a[i] = 8'(i * 7) ^ 8'(i >> 8);
      ref_a[i] = mem_a[i];
      mem_b[i] = 8'(i * 13) ^ 8'(i >> 9);
      ref_b[i] = mem_b[i];
    end
    mem_a[19'h00123] = 8'hA5; ref_a[19'h00123] = 8'hA5;
    mem_a[19'h00200] = 8'h3C; ref_a[19'h00200] = 8'h3C;

    pix_on = 1'b0; fix_req = 1'b0; fix_addr = '0;
    rec_hit = 1'b0; rec_data = '0; exp_hit = 1'b0; exp_data = '0; cur_hit = 1'b0; cur_addr = '0;
    if_a.pix_req = 1'b0; if_a.pix_addr = '0;
    if_b.pix_req = 1'b0; if_b.pix_addr = '0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_rdy", 32'(if_a.bus_rdy), 32'(1));
    chk("rst_we_l", 32'(if_a.ram_we_l), 32'(1));
    chk("rst_doe", 32'(if_a.ram_doe), 32'(0));
    chk("rst_pix_valid", 32'(if_a.pix_valid), 32'(0));
    chk("rst_pix_data", 32'(if_a.pix_data), 32'(0));
    chk("rst_isa_dout", 32'(if_a.isa_dout), 32'(0));
    chk("rst_ram_a", 32'(if_a.ram_a), 32'(0));
    reset_l = 1'b1;

    // Pixel fetch at phase 0, data one cycle later.
    idle_until(0);
    fix_req = 1'b1; fix_addr = 19'h00123;
    cycle(); sample();
    cycle(); sample();
    chk("pix_a5", 32'(if_a.pix_data), 32'(8'hA5));

    // Write at phase 0: SETUP 2, strobe 3, ready 4.
    idle_until(0);
    xact(1'b0, 1'b0, 1'b1, 19'h01000, 8'h5A, 1'b0, 2);

    // Read held long after completion must not repeat.
    idle_until(10);
    xact(1'b0, 1'b1, 1'b0, 19'h00200, 8'h00, 1'b0, 4);

    // Wrap window on the second instance: request at 5, SETUP 31, STROBE 0.
    idle_until(5);
    xact(1'b1, 1'b0, 1'b1, 19'h0ABCD, 8'hC3, 1'b0, 1);
    idle_until(20);
    xact(1'b1, 1'b1, 1'b0, 19'h0ABCD, 8'h00, 1'b0, 1);

    // Write colliding with a pixel fetch in a pixel slot.
    idle_until(4);
    fix_req = 1'b1; fix_addr = 19'h01000;
    xact(1'b0, 1'b0, 1'b1, 19'h07777, 8'h99, 1'b0, 1);
    xact(1'b0, 1'b1, 1'b0, 19'h01000, 8'h00, 1'b0, 0);

    // Randomized traffic with background pixel fetches.
    pix_on = 1'b1;
    for (int t = 0; t < 28; t++) begin
      int op, gap, hold;
      bit rd, wr, posted;
      logic [18:0] a;
      logic [7:0]  d;
      op  = int'($urandom_range(0, 3));
      rd  = (op == 0) || (op == 3);
      wr  = (op != 0);
      gap = int'($urandom_range(0, 5));
      hold   = int'($urandom_range(0, 2));
      posted = ($urandom_range(0, 3) == 0);
      d = 8'($urandom);
      if (!wr && wq.size() > 0 && $urandom_range(0, 1) == 1)
        a = wq[$urandom_range(0, wq.size() - 1)];
      else
        a = 19'($urandom);
      if (wr) wq.push_back(a);
      repeat (gap) begin cycle(); sample(); end
      xact(1'b0, rd, wr, a, d, posted, hold);
    end

    // Reset in the middle of a write strobe aborts it.
    pix_on = 1'b0;
    ra = 19'h05555;
    old = ref_a[ra];
    cycle();
    drive(1'b0, 1'b0, 1'b1, ra, 8'hEE);
    sample();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      sample();
      if (if_a.ram_we_l === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("we_low_seen", 32'(seen), 32'(1));
    reset_l = 1'b0;
    #1;
    chk("arst_we_l", 32'(if_a.ram_we_l), 32'(1));
    chk("arst_bus_rdy", 32'(if_a.bus_rdy), 32'(1));
    chk("arst_doe", 32'(if_a.ram_doe), 32'(0));
    chk("arst_pix_valid", 32'(if_a.pix_valid), 32'(0));
    drive(1'b0, 1'b0, 1'b0, ra, 8'hEE);
    cycle(); sample();
    cycle(); sample();
    reset_l = 1'b1;
    for (int i = 0; i < 36; i++) begin
      cycle();
      sample();
      chk("post_rst_we_l", 32'(if_a.ram_we_l), 32'(1));
      chk("post_rst_rdy", 32'(if_a.bus_rdy), 32'(1));
    end
    chk("no_replay", 32'(mem_a[ra]), 32'(old));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
